request_queue: RTL
==================

Name: request_queue

Overview:
- Bounded in-order request FIFO between the trace parser and the DRAM command scheduler.
- Captures each parsed operation strobe (op, address, CPU issue time) and presents the oldest entry to the scheduler through a valid/ready handshake.
- Tracks per-entry age in CPU cycles and drives back-pressure to the parser, which holds in its WAITE state while the queue is full.

Parameters:
- QUEUE_SIZE, 16, number of entries; must be a power of two ≥ 2.
- AGE_MAX, 100, saturation value of the per-entry age counter; must fit in age_counter_t (7 bits).
- CNT_W, $clog2(QUEUE_SIZE)+1, occupancy counter width (5 at default).

Ports:
- clk  in  1  CPU clock (3.2 GHz domain).
- rst_n  in  1  synchronous active-low reset.
- in_op  in  68  parser_out_struct_t {op_ready_s, opcode[1:0], address[32:0], time_cpu[31:0]}.
- queue_full  out  1  occupancy == QUEUE_SIZE; parser back-pressure.
- queue_empty  out  1  occupancy == 0.
- occupancy  out  CNT_W  number of valid entries.
- out_valid  out  1  head entry valid.
- out_ready  in  1  scheduler accepts head this cycle.
- out_opcode  out  2  head parsed_op_t.
- out_address  out  33  head address.
- out_time_cpu  out  32  head CPU issue time.
- out_age  out  7  head age (age_counter_t).
- age_alarm  out  1  head age == AGE_MAX.
- overflow_err  out  1  sticky: a request was dropped because the queue was full.

Behaviour:
Reset
- All outputs go to 0 on the first rising clk with rst_n=0.
- out_opcode resets to NOP.
- Pointers, occupancy and all ages are cleared. Storage contents are don't-care.
- Reset mid-operation discards every entry; overflow_err clears.

Push and pop
- push_req = in_op.op_ready_s && in_op.opcode != NOP. A NOP with the strobe set is ignored.
- pop = out_valid && out_ready. When out_valid=0, out_ready is ignored.
- Circular buffer: wr_ptr and rd_ptr are log2(QUEUE_SIZE) bits and wrap from QUEUE_SIZE-1 to 0. Occupancy is tracked separately.

Write acceptance
- Write accepted = push_req && (!queue_full || pop).
- Push while full with a simultaneous pop is accepted; occupancy is unchanged.
- Push while full without a pop drops the request and sets overflow_err=1 on the next edge. overflow_err holds until reset.

Latency and output path
- An accepted push is visible one cycle later: occupancy increments and, if the queue was empty, out_valid=1 on the next cycle.
- There is no same-cycle bypass; a push into an empty queue with out_ready=1 does not pop that cycle.
- Head outputs are driven combinationally from the rd_ptr storage slot. They are stable while out_valid=1 and out_ready=0.
- When out_valid=0, the head outputs show opcode NOP, address 0, time 0, age 0.

Occupancy and status
- Next occupancy = occupancy + accepted_push − pop.
- queue_full and queue_empty are combinational decodes of the registered occupancy.

Age tracking
- A newly written entry holds age 0 on the cycle it first becomes valid.
- Every valid entry's age increments by 1 each cycle and saturates at AGE_MAX; it never wraps.
- Ages travel with their slots: a pop does not reset other entries' ages.
- age_alarm = out_valid && out_age == AGE_MAX.

There is no FSM beyond pointer/occupancy state; the implicit states are EMPTY, PARTIAL and FULL, decided by occupancy.

Optional Feature:
- Macro: REQUEST_QUEUE_STATS_EN.
- When defined, add two output ports, push_count[31:0] and pop_count[31:0]:
  - push_count counts accepted pushes; pop_count counts pops.
  - Both reset to 0 and wrap modulo 2^32.
  - A dropped push does not increment push_count.
- When undefined, these ports and counters do not exist and the rest of the behaviour is identical.

Test Plan:
1. Reset then a single push {DATA_READ, addr 0x1_0000_0040, time 25} with out_ready=0:
   - next cycle: out_valid=1, occupancy=1, out_address=0x100000040, out_time_cpu=25, out_age=0.
   - 10 cycles later: out_age=10.
2. Hold out_ready=0 for 120 cycles after one push:
   - out_age saturates at 100 with age_alarm=1 from cycle 100 on; no wrap.
3. 16 back-to-back pushes (addresses 0..15) with out_ready=0, then a 17th push:
   - queue_full=1 and occupancy=16 after the 16th push.
   - 17th push is dropped and overflow_err=1.
   - Draining with out_ready=1 yields addresses 0..15 in order; queue_empty=1 at the end.
4. Queue full plus a simultaneous push (addr 0xAA) and pop:
   - occupancy stays 16 and overflow_err stays 0.
   - 0xAA emerges 16th after the pop.
5. Push with opcode NOP and op_ready_s=1 into an empty queue:
   - no change: occupancy=0, out_valid=0.
6. Assert rst_n=0 for one cycle while occupancy=7 and overflow_err=1:
   - next cycle occupancy=0, out_valid=0, overflow_err=0.
   - With REQUEST_QUEUE_STATS_EN, push_count=0 and pop_count=0.

Source files
------------

// File: rtl/request_queue_if.sv
// Parser/scheduler-facing signals of request_queue; slave is the queue's view, master the surrounding logic.
interface request_queue_if #(
  parameter int CNT_W = 5
);
  logic [67:0]      in_op;
  logic             queue_full;
  logic             queue_empty;
  logic [CNT_W-1:0] occupancy;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       out_opcode;
  logic [32:0]      out_address;
  logic [31:0]      out_time_cpu;
  logic [6:0]       out_age;
  logic             age_alarm;
  logic             overflow_err;

  modport slave (
    input  in_op, out_ready,
    output queue_full, queue_empty, occupancy, out_valid, out_opcode,
           out_address, out_time_cpu, out_age, age_alarm, overflow_err
  );

  modport master (
    output in_op, out_ready,
    input  queue_full, queue_empty, occupancy, out_valid, out_opcode,
           out_address, out_time_cpu, out_age, age_alarm, overflow_err
  );
endinterface

// File: rtl/request_queue.sv
// In-order request FIFO between trace parser and DRAM scheduler with per-entry age tracking; head visible 1 cycle after push.
// Define REQUEST_QUEUE_STATS_EN to add push_count/pop_count ports.
module request_queue #(
  parameter int QUEUE_SIZE = 16,
  parameter int AGE_MAX    = 100,
  parameter int CNT_W      = $clog2(QUEUE_SIZE) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  request_queue_if.slave  rq
`ifdef REQUEST_QUEUE_STATS_EN
  ,
  output logic [31:0]     push_count,
  output logic [31:0]     pop_count
`endif
);

  localparam int PTR_W = $clog2(QUEUE_SIZE);

  typedef logic [1:0] parsed_op_t;
  typedef logic [6:0] age_counter_t;

  localparam parsed_op_t OP_NOP = 2'd0;
  localparam age_counter_t AGE_SAT = age_counter_t'(AGE_MAX);

  typedef struct packed {
    logic        op_ready_s;
    parsed_op_t  opcode;
    logic [32:0] address;
    logic [31:0] time_cpu;
  } parser_out_struct_t;

  typedef struct packed {
    parsed_op_t  opcode;
    logic [32:0] address;
    logic [31:0] time_cpu;
  } entry_t;

  parser_out_struct_t in_op;
  assign in_op = rq.in_op;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic             ovf_q, ovf_d;
  logic             vld_q [QUEUE_SIZE];
  logic             vld_d [QUEUE_SIZE];
  age_counter_t     age_q [QUEUE_SIZE];
  age_counter_t     age_d [QUEUE_SIZE];
  entry_t           slot_q [QUEUE_SIZE];
  entry_t           slot_d [QUEUE_SIZE];

`ifdef REQUEST_QUEUE_STATS_EN
  logic [31:0] push_cnt_q, push_cnt_d;
  logic [31:0] pop_cnt_q, pop_cnt_d;
`endif

  logic out_valid;
  logic queue_full;
  logic push_req;
  logic pop;
  logic accept;

  assign out_valid  = (occ_q != '0);
  assign queue_full = (occ_q == CNT_W'(QUEUE_SIZE));

  always_comb begin
    push_req = in_op.op_ready_s && (in_op.opcode != OP_NOP);
    pop      = out_valid && rq.out_ready;
    // A full queue still takes a push when the head leaves in the same cycle.
    accept   = push_req && (!queue_full || pop);

    wr_ptr_d = accept ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop    ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    occ_d    = occ_q + CNT_W'(accept) - CNT_W'(pop);
    ovf_d    = ovf_q | (push_req && !accept);

    for (int i = 0; i < QUEUE_SIZE; i++) begin
      vld_d[i]  = vld_q[i];
      slot_d[i] = slot_q[i];
      age_d[i]  = age_q[i];
      if (vld_q[i] && (age_q[i] != AGE_SAT)) begin
        age_d[i] = age_q[i] + age_counter_t'(1);
      end
    end

    if (pop) begin
      vld_d[rd_ptr_q] = 1'b0;
    end

    // Write after pop so a full-queue swap into the head slot restarts at age 0.
    if (accept) begin
      vld_d[wr_ptr_q]           = 1'b1;
      age_d[wr_ptr_q]           = '0;
      slot_d[wr_ptr_q].opcode   = in_op.opcode;
      slot_d[wr_ptr_q].address  = in_op.address;
      slot_d[wr_ptr_q].time_cpu = in_op.time_cpu;
    end

`ifdef REQUEST_QUEUE_STATS_EN
    push_cnt_d = accept ? push_cnt_q + 32'd1 : push_cnt_q;
    pop_cnt_d  = pop    ? pop_cnt_q  + 32'd1 : pop_cnt_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < QUEUE_SIZE; i++) begin
        vld_q[i] <= 1'b0;
        age_q[i] <= '0;
      end
`ifdef REQUEST_QUEUE_STATS_EN
      push_cnt_q <= '0;
      pop_cnt_q  <= '0;
`endif
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      ovf_q    <= ovf_d;
      for (int i = 0; i < QUEUE_SIZE; i++) begin
        vld_q[i] <= vld_d[i];
        age_q[i] <= age_d[i];
      end
`ifdef REQUEST_QUEUE_STATS_EN
      push_cnt_q <= push_cnt_d;
      pop_cnt_q  <= pop_cnt_d;
`endif
    end
  end

  // Payload storage needs no reset; validity comes from occupancy.
  always_ff @(posedge clk) begin
    for (int i = 0; i < QUEUE_SIZE; i++) begin
      slot_q[i] <= slot_d[i];
    end
  end

  always_comb begin
    rq.out_valid    = out_valid;
    rq.out_opcode   = OP_NOP;
    rq.out_address  = '0;
    rq.out_time_cpu = '0;
    rq.out_age      = '0;
    if (out_valid) begin
      rq.out_opcode   = slot_q[rd_ptr_q].opcode;
      rq.out_address  = slot_q[rd_ptr_q].address;
      rq.out_time_cpu = slot_q[rd_ptr_q].time_cpu;
      rq.out_age      = age_q[rd_ptr_q];
    end
  end

  assign rq.age_alarm    = out_valid && (age_q[rd_ptr_q] == AGE_SAT);
  assign rq.queue_full   = queue_full;
  assign rq.queue_empty  = (occ_q == '0);
  assign rq.occupancy    = occ_q;
  assign rq.overflow_err = ovf_q;

`ifdef REQUEST_QUEUE_STATS_EN
  assign push_count = push_cnt_q;
  assign pop_count  = pop_cnt_q;
`endif

endmodule
